// File: rtl/uf_load_cdb.sv
// LOAD functional unit: effective-address read, memory wait, CDB arbitration and one-cycle broadcast.
// Optional memory-wait timeout enabled by defining LOAD_MEM_TIMEOUT_EN.
module uf_load_cdb #(
  parameter int                DATA_W         = 16,
  parameter int                ADDR_W         = 7,
  parameter int                TAG_W          = 3,
  parameter logic [DATA_W-1:0] VAL_SEM_VALOR  = 16'hFFF0,
  parameter logic [TAG_W-1:0]  TAG_SEM_VALOR  = 3'b000,
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Ready_to_uf,
  input  logic [DATA_W-1:0] Op1,
  input  logic [DATA_W-1:0] Op2,
  input  logic [TAG_W-1:0]  Rs_tag,
  output logic              Uf_busy,
  output logic              Mem_rd,
  output logic [ADDR_W-1:0] Mem_addr,
  input  logic              Mem_valid,
  input  logic [DATA_W-1:0] Mem_data,
  output logic              CDB_req,
  input  logic              CDB_grant,
  output logic [TAG_W-1:0]  Qi_CDB,
  output logic [DATA_W-1:0] Qi_CDB_data,
  output logic              Done,
  output logic              Err
);

  typedef enum logic [2:0] {IDLE, ADDR, MEM_WAIT, CDB_REQ, BCAST} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_timeout;
  logic [ADDR_W-1:0]   w_ea;
  logic [TAG_W-1:0]    r_tag;
  logic [DATA_W-1:0]   r_data;
  logic                r_busy;
  logic                r_mem_rd;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_cdb_req;
  logic [TAG_W-1:0]    r_qi;
  logic [DATA_W-1:0]   r_qi_data;
  logic                r_done;
  logic                r_err;

  assign w_accept = Ready_to_uf && (Op1 != VAL_SEM_VALOR) && (Op2 != VAL_SEM_VALOR)
                    && (Rs_tag != TAG_SEM_VALOR);
  // Low ADDR_W bits of the sum equal the truncated DATA_W-wide sum.
  assign w_ea     = Op1[ADDR_W-1:0] + Op2[ADDR_W-1:0];

`ifdef LOAD_MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_cnt;

  // r_cnt equals the number of MEM_WAIT cycles already spent without data.
  always_ff @(posedge Clock) begin
    if (Reset || r_state != MEM_WAIT) r_cnt <= '0;
    else if (!Mem_valid)              r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout = (r_state == MEM_WAIT) && !Mem_valid
                     && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_next = ADDR;
      ADDR:     w_next = MEM_WAIT;
      MEM_WAIT: begin
        if (Mem_valid)      w_next = CDB_REQ;
        else if (w_timeout) w_next = BCAST;
      end
      CDB_REQ:  if (CDB_grant) w_next = BCAST;
      BCAST:    w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Control and outputs: registered from the next state so every port is a flop.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_cdb_req  <= 1'b0;
      r_qi       <= TAG_SEM_VALOR;
      r_qi_data  <= VAL_SEM_VALOR;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_busy    <= (w_next != IDLE);
      r_mem_rd  <= (w_next == ADDR);
      r_cdb_req <= (w_next == CDB_REQ);
      r_done    <= (w_next == BCAST);
      r_err     <= w_timeout;
      r_qi      <= (w_next == BCAST) ? r_tag : TAG_SEM_VALOR;
      r_qi_data <= (w_next == BCAST && !w_timeout) ? r_data : VAL_SEM_VALOR;
      if (r_state == IDLE && w_accept) r_mem_addr <= w_ea;
    end
  end

  // Datapath latches: no reset, qualified by the state that owns them.
  always_ff @(posedge Clock) begin
    if (r_state == IDLE && w_accept)      r_tag  <= Rs_tag;
    if (r_state == MEM_WAIT && Mem_valid) r_data <= Mem_data;
  end

  assign Uf_busy     = r_busy;
  assign Mem_rd      = r_mem_rd;
  assign Mem_addr    = r_mem_addr;
  assign CDB_req     = r_cdb_req;
  assign Qi_CDB      = r_qi;
  assign Qi_CDB_data = r_qi_data;
  assign Done        = r_done;
  assign Err         = r_err;

endmodule

// File: tb/tb_uf_load_cdb.sv
// Directed bench for uf_load_cdb with a broadcast scoreboard; timeout runs need LOAD_MEM_TIMEOUT_EN.
module tb_uf_load_cdb;

  localparam int TO = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Ready_to_uf;
  logic [15:0] Op1, Op2;
  logic [2:0]  Rs_tag;
  logic        Uf_busy, Mem_rd, Mem_valid, CDB_req, CDB_grant, Done, Err;
  logic [6:0]  Mem_addr;
  logic [15:0] Mem_data, Qi_CDB_data;
  logic [2:0]  Qi_CDB;

  typedef struct {
    logic [2:0]  tag;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  uf_load_cdb #(.DATA_W(16), .ADDR_W(7), .TAG_W(3), .VAL_SEM_VALOR(16'hFFF0),
                .TAG_SEM_VALOR(3'b000), .TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock), .Reset(Reset), .Ready_to_uf(Ready_to_uf), .Op1(Op1), .Op2(Op2),
    .Rs_tag(Rs_tag), .Uf_busy(Uf_busy), .Mem_rd(Mem_rd), .Mem_addr(Mem_addr),
    .Mem_valid(Mem_valid), .Mem_data(Mem_data), .CDB_req(CDB_req), .CDB_grant(CDB_grant),
    .Qi_CDB(Qi_CDB), .Qi_CDB_data(Qi_CDB_data), .Done(Done), .Err(Err));

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] t, input logic [15:0] d, input logic e);
    exp_t x;
    x.tag = t; x.data = d; x.err = e;
    sb.push_back(x);
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    chk({nm, "_sb_avail"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({nm, "_done"},  Done,        1);
      chk({nm, "_tag"},   Qi_CDB,      e.tag);
      chk({nm, "_data"},  Qi_CDB_data, e.data);
      chk({nm, "_err"},   Err,         e.err);
    end
  endtask

  task automatic wait_bcast(input string nm, input int budget, output int cyc);
    cyc = 0;
    while (Done !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    chk({nm, "_seen"}, Done, 1);
    if (Done === 1'b1) pop_check(nm);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_busy"}, Uf_busy,     0);
    chk({nm, "_rd"},   Mem_rd,      0);
    chk({nm, "_req"},  CDB_req,     0);
    chk({nm, "_qi"},   Qi_CDB,      0);
    chk({nm, "_qid"},  Qi_CDB_data, 16'hFFF0);
    chk({nm, "_done"}, Done,        0);
    chk({nm, "_err"},  Err,         0);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] t);
    Op1 = a; Op2 = b; Rs_tag = t; Ready_to_uf = 1'b1;
    tick();
    Ready_to_uf = 1'b0;
  endtask

  initial begin
    int cyc;
    Reset = 1'b1; Ready_to_uf = 1'b0; Op1 = 16'h0; Op2 = 16'h0; Rs_tag = 3'd0;
    Mem_valid = 1'b0; Mem_data = 16'h0; CDB_grant = 1'b1;
    tick(); tick();
    chk_idle("reset");
    chk("reset_addr", Mem_addr, 0);
    Reset = 1'b0;
    tick();

    // Basic load: accept cycle + 4 cycles to the broadcast.
    push(3'd2, 16'h1234, 1'b0);
    issue(16'h0010, 16'h0005, 3'd2);
    chk("basic_rd", Mem_rd, 1);
    chk("basic_addr", Mem_addr, 7'h15);
    chk("basic_busy", Uf_busy, 1);
    tick();
    chk("basic_rd_pulse", Mem_rd, 0);
    chk("basic_addr_hold", Mem_addr, 7'h15);
    Mem_valid = 1'b1; Mem_data = 16'h1234;
    tick();
    Mem_valid = 1'b0; Mem_data = 16'h0;
    chk("basic_req", CDB_req, 1);
    tick();
    pop_check("basic");
    tick();
    chk_idle("basic_after");

    // Wrap of the effective address; sentinel data from memory is passed through.
    push(3'd4, 16'hFFF0, 1'b0);
    issue(16'hFFFF, 16'h0003, 3'd4);
    chk("wrap_addr", Mem_addr, 7'h02);
    tick();
    Mem_valid = 1'b1; Mem_data = 16'hFFF0;
    tick();
    Mem_valid = 1'b0;
    wait_bcast("wrap", 6, cyc);
    tick();

    // Sentinel operands / tag, and Reset beating Ready_to_uf: no accept.
    issue(16'hFFF0, 16'h0001, 3'd1);
    tick();
    chk_idle("sent_op1");
    issue(16'h0001, 16'hFFF0, 3'd1);
    tick();
    chk("sent_op2_busy", Uf_busy, 0);
    issue(16'h0001, 16'h0002, 3'd0);
    tick();
    chk("sent_tag_busy", Uf_busy, 0);
    chk("sent_tag_rd", Mem_rd, 0);
    Reset = 1'b1;
    issue(16'h0001, 16'h0002, 3'd1);
    Reset = 1'b0;
    chk("rst_rdy_busy", Uf_busy, 0);
    chk("rst_rdy_rd", Mem_rd, 0);

    // Grant stall with a competing request that must be ignored.
    CDB_grant = 1'b0;
    push(3'd5, 16'h5A5A, 1'b0);
    issue(16'h0020, 16'h0001, 3'd5);
    chk("stall_addr", Mem_addr, 7'h21);
    tick();
    Mem_valid = 1'b1; Mem_data = 16'h5A5A;
    tick();
    Mem_valid = 1'b0;
    Op1 = 16'h0040; Op2 = 16'h0002; Rs_tag = 3'd7; Ready_to_uf = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", CDB_req, 1);
      chk("stall_qi", Qi_CDB, 0);
      chk("stall_done", Done, 0);
      tick();
    end
    CDB_grant = 1'b1; Ready_to_uf = 1'b0;
    chk("stall_req_last", CDB_req, 1);
    tick();
    chk("stall_req_drop", CDB_req, 0);
    pop_check("stall");
    tick();
    chk_idle("stall_after");
    chk("stall_addr_kept", Mem_addr, 7'h21);

    // Reset while waiting on memory; the late data must not be broadcast.
    issue(16'h0003, 16'h0004, 3'd3);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk_idle("rst_mw");
    chk("rst_mw_addr", Mem_addr, 0);
    Mem_valid = 1'b1; Mem_data = 16'hBEEF;
    tick();
    Mem_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("rst_mw_nodone", Done, 0);
      chk("rst_mw_nobusy", Uf_busy, 0);
      tick();
    end
    chk_idle("rst_mw_end");

`ifdef LOAD_MEM_TIMEOUT_EN
    // Timeout without data: MEM_WAIT lasts TO cycles, then an error broadcast.
    push(3'd6, 16'hFFF0, 1'b1);
    issue(16'h0008, 16'h0008, 3'd6);
    tick();
    wait_bcast("tmo", 20, cyc);
    chk("tmo_lat", cyc, TO);
    tick();
    chk_idle("tmo_after");

    // Data arriving in the timeout cycle wins.
    push(3'd1, 16'hCAFE, 1'b0);
    issue(16'h0008, 16'h0009, 3'd1);
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      chk("tmo2_wait_done", Done, 0);
      tick();
    end
    Mem_valid = 1'b1; Mem_data = 16'hCAFE;
    tick();
    Mem_valid = 1'b0;
    chk("tmo2_req", CDB_req, 1);
    chk("tmo2_noerr", Err, 0);
    wait_bcast("tmo2", 6, cyc);
    tick();
    chk_idle("tmo2_after");
`endif

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uf_load_cdb.md
Name: uf_load_cdb

Overview:
- LOAD functional unit at the consuming end of the reservation-station operand selector.
- Accepts Op1 (base) and Op2 (offset) when Ready_to_uf is high, computes the effective address and issues a memory read.
- Waits for the memory data, arbitrates for the Common Data Bus (CDB), then broadcasts tag and data on Qi_CDB/Qi_CDB_data for one cycle.
- Reservation stations snoop that broadcast to resolve Qj/Qk.

Parameters:
- DATA_W, 16, operand/data width
- ADDR_W, 7, memory address width (effective address truncated to this)
- TAG_W, 3, reservation-station tag width
- VAL_SEM_VALOR, 16'hFFF0, "no value" sentinel for operands and CDB data
- TAG_SEM_VALOR, 3'b000, "no tag" sentinel for CDB tag
- TIMEOUT_CYCLES, 16, memory wait limit (used only with the optional feature)

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high
- Ready_to_uf  in  1  operands valid from selector
- Op1  in  DATA_W  base operand
- Op2  in  DATA_W  offset operand
- Rs_tag  in  TAG_W  tag of the issuing reservation station
- Uf_busy  out  1  unit holds an operation (IDLE -> 0)
- Mem_rd  out  1  one-cycle read strobe
- Mem_addr  out  ADDR_W  read address
- Mem_valid  in  1  read data valid
- Mem_data  in  DATA_W  read data
- CDB_req  out  1  CDB request
- CDB_grant  in  1  CDB grant
- Qi_CDB  out  TAG_W  broadcast tag
- Qi_CDB_data  out  DATA_W  broadcast data
- Done  out  1  one-cycle pulse, reservation station may free the entry
- Err  out  1  one-cycle pulse, load aborted (tied 0 without the optional feature)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports Clock and Reset. All outputs are registered.
- Reset values: Uf_busy=0, Mem_rd=0, Mem_addr=0, CDB_req=0, Qi_CDB=TAG_SEM_VALOR, Qi_CDB_data=VAL_SEM_VALOR, Done=0, Err=0, state=IDLE.
- FSM states: IDLE, ADDR, MEM_WAIT, CDB_REQ, BCAST.
- IDLE:
  - Accept when Ready_to_uf=1, Op1!=VAL_SEM_VALOR, Op2!=VAL_SEM_VALOR and Rs_tag!=TAG_SEM_VALOR.
  - On accept: latch Op1, Op2, Rs_tag; go to ADDR; Uf_busy=1 from the next cycle.
  - Otherwise stay in IDLE; nothing is latched.
- ADDR:
  - Mem_addr = (Op1+Op2) mod 2^DATA_W, truncated to the low ADDR_W bits; no overflow flag.
  - Mem_rd=1 for exactly this one cycle; go to MEM_WAIT.
  - Mem_valid is ignored in ADDR.
- MEM_WAIT:
  - Mem_addr is held.
  - On Mem_valid=1: latch Mem_data and go to CDB_REQ.
  - Minimum latency is 1 cycle after the Mem_rd cycle.
- CDB_REQ:
  - CDB_req=1, held until CDB_grant=1 is sampled; then go to BCAST with CDB_req=0.
  - CDB_grant outside CDB_REQ is ignored.
- BCAST:
  - Exactly one cycle: Qi_CDB=latched tag, Qi_CDB_data=latched data, Done=1.
  - Next cycle: Qi_CDB and Qi_CDB_data return to their sentinels, Done=0, Uf_busy=0, state=IDLE.
- Data equal to VAL_SEM_VALOR loaded from memory is broadcast unchanged; consumers handle that collision.
- Latency: accept edge to BCAST is 4 cycles with 1-cycle memory and immediate grant.
- Throughput: a new accept is possible the cycle after BCAST, one load in flight at most.
- Ready_to_uf is ignored while Uf_busy=1; the selector holds it until Done.
- Reset mid-operation: the FSM returns to IDLE and latched operands are discarded. A late Mem_valid seen in IDLE is ignored and no broadcast occurs.
- Reset with Ready_to_uf: Reset and Ready_to_uf in the same cycle means Reset wins; no accept.

Optional Feature:
- Macro: LOAD_MEM_TIMEOUT_EN.
- Defined:
  - A counter starts at 0 on entry to MEM_WAIT and increments each cycle without Mem_valid.
  - On reaching TIMEOUT_CYCLES: go to BCAST, driving Qi_CDB=tag, Qi_CDB_data=VAL_SEM_VALOR, Done=1 and Err=1.
  - Mem_valid in the same cycle as the timeout takes priority, giving a normal load.
- Undefined: no counter; MEM_WAIT waits indefinitely; Err is constant 0.

Test Plan:
- Basic load: Op1=16'h0010, Op2=16'h0005, Rs_tag=3'd2, Ready_to_uf=1; memory 1-cycle with Mem_data=16'h1234, grant immediate -> Mem_rd pulse with Mem_addr=7'h15; 4 cycles after accept Qi_CDB=2 and Qi_CDB_data=16'h1234 for one cycle with Done=1.
- Wrap: Op1=16'hFFFF, Op2=16'h0003 -> Mem_addr=7'h02.
- Sentinels: Op1=16'hFFF0 with Ready_to_uf=1, or Rs_tag=0 -> no accept, Uf_busy stays 0, no Mem_rd.
- Grant stall: hold CDB_grant=0 for 5 cycles in CDB_REQ -> CDB_req stays 1 and Qi_CDB=0; on grant, BCAST occurs the next cycle. A second Ready_to_uf during the stall is ignored.
- Reset in MEM_WAIT: assert Reset, then pulse Mem_valid with 16'hBEEF -> no broadcast, all outputs at reset values.
- LOAD_MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, Mem_valid never asserted -> BCAST with Qi_CDB=tag, Qi_CDB_data=16'hFFF0, Done=1, Err=1. A second run with Mem_valid in the timeout cycle -> normal data broadcast and Err=0.
